// File: rtl/dca_lsu_issue_arbiter_pkg.sv
// Shared constants and helpers for the LSU issue arbiter.
// Optional feature macro: DCA_LSU_ARB_WRITE_PRIORITY_EN (write-opcode priority).
package dca_lsu_issue_arbiter_pkg;
  localparam int BW_DCA_MATRIX_LSU_INST = 32;
  localparam int BW_LSU_OPCODE          = 4;
  localparam logic [BW_LSU_OPCODE-1:0] DCA_MATRIX_LSU_INST_OPCODE_WRITE = 4'h2;

  localparam int NUM_LSU_REQ = 3;
  localparam int BW_REQ_ID   = 2;
  localparam int LSU0        = 0;
  localparam int LSU1        = 1;
  localparam int LSU2        = 2;

  typedef logic [BW_REQ_ID-1:0]   req_id_t;
  typedef logic [NUM_LSU_REQ-1:0] req_vec_t;

  // Requester ID to one-hot requester vector.
  function automatic req_vec_t id2oh(req_id_t id);
    req_vec_t oh;
    oh = '0;
    for (int i = 0; i < NUM_LSU_REQ; i++) oh[i] = (id == req_id_t'(i));
    return oh;
  endfunction
endpackage

// File: rtl/dca_lsu_issue_arbiter_if.sv
// Request / LSU handshake bundle. master = requesters + LSU, slave = arbiter.
interface dca_lsu_issue_arbiter_if #(
  parameter int BW_INST = dca_lsu_issue_arbiter_pkg::BW_DCA_MATRIX_LSU_INST
);
  logic [2:0]           req_valid;
  logic [2:0]           req_ready;
  logic [3*BW_INST-1:0] req_inst;
  logic                 lsu_valid;
  logic                 lsu_ready;
  logic [BW_INST-1:0]   lsu_inst;
  logic                 lsu_done;
  logic [2:0]           req_done;

  modport master (output req_valid, req_inst, lsu_ready, lsu_done,
                  input  req_ready, lsu_valid, lsu_inst, req_done);
  modport slave  (input  req_valid, req_inst, lsu_ready, lsu_done,
                  output req_ready, lsu_valid, lsu_inst, req_done);
endinterface

// File: rtl/dca_lsu_issue_arbiter_id_fifo.sv
// dca_lsu_id_fifo: in-order FIFO of requester IDs for outstanding LSU work.
module dca_lsu_id_fifo
  import dca_lsu_issue_arbiter_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int BW_CNT = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              enable,
  input  logic              push,
  input  req_id_t           push_id,
  input  logic              pop,
  output req_id_t           pop_id,
  output logic [BW_CNT-1:0] count
);
  localparam int PW = $clog2(DEPTH);

  req_id_t           mem_q [DEPTH];
  req_id_t           mem_d [DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [BW_CNT-1:0] count_q, count_d;

  assign pop_id = mem_q[rd_ptr_q];
  assign count  = count_q;

  // Next-state: pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (enable) begin
      if (push) begin
        mem_d[wr_ptr_q] = push_id;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + BW_CNT'(push) - BW_CNT'(pop);
    end
  end

  // State registers; clear behaves exactly like reset.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end
endmodule

// File: rtl/dca_lsu_issue_arbiter.sv
// Round-robin issue arbiter sharing one matrix LSU among LSU0/LSU1/LSU2,
// with in-order completion routing back to the issuing requester.
// Optional: `define DCA_LSU_ARB_WRITE_PRIORITY_EN to let write-opcode
// requests pre-empt round-robin.
module dca_lsu_issue_arbiter
  import dca_lsu_issue_arbiter_pkg::*;
#(
  parameter int BW_INST     = BW_DCA_MATRIX_LSU_INST,
  parameter int TRACK_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic                    enable,
  dca_lsu_issue_arbiter_if.slave  bus,
  output logic                    busy,
  output logic                    err
);
  localparam int BW_CNT = $clog2(TRACK_DEPTH) + 1;

  req_id_t            rr_q, rr_d;
  logic               lsu_valid_q, lsu_valid_d;
  logic [BW_INST-1:0] lsu_inst_q, lsu_inst_d;
  req_vec_t           req_done_q, req_done_d;
  logic               err_q, err_d;

  req_vec_t          cand, is_wr;
  req_id_t           win_id, pop_id;
  logic              grant, pop, empty;
  logic [BW_CNT-1:0] count;

  // Per-requester write-opcode detect (only consulted with priority enabled).
  for (genvar g = 0; g < NUM_LSU_REQ; g++) begin : g_opc
    assign is_wr[g] = bus.req_valid[g] &&
      (bus.req_inst[g*BW_INST +: BW_LSU_OPCODE] == DCA_MATRIX_LSU_INST_OPCODE_WRITE);
  end

  // Candidate set, then first valid candidate starting from the rr pointer.
  always_comb begin
    int idx;
    logic found;
`ifdef DCA_LSU_ARB_WRITE_PRIORITY_EN
    cand = (|is_wr) ? is_wr : bus.req_valid;
`else
    cand = bus.req_valid;
`endif
    win_id = '0;
    found  = 1'b0;
    for (int k = 0; k < NUM_LSU_REQ; k++) begin
      idx = int'(rr_q) + k;
      if (idx >= NUM_LSU_REQ) idx = idx - NUM_LSU_REQ;
      if (!found && cand[idx]) begin
        found  = 1'b1;
        win_id = req_id_t'(idx);
      end
    end
  end

  // Grant uses the registered count, so a same-cycle completion at full
  // does not open a slot until the next cycle.
  assign grant = enable && (!lsu_valid_q || bus.lsu_ready) &&
                 (count < BW_CNT'(TRACK_DEPTH)) && (|bus.req_valid);
  assign bus.req_ready = grant ? id2oh(win_id) : '0;
  assign empty         = (count == '0);
  assign pop           = enable && bus.lsu_done && !empty;

  // Output stage, pointer, completion routing and sticky error.
  always_comb begin
    lsu_valid_d = lsu_valid_q;
    lsu_inst_d  = lsu_inst_q;
    rr_d        = rr_q;
    req_done_d  = '0;
    err_d       = err_q;
    if (enable) begin
      if (grant) begin
        lsu_valid_d = 1'b1;
        lsu_inst_d  = bus.req_inst[int'(win_id)*BW_INST +: BW_INST];
        rr_d        = (win_id == req_id_t'(LSU2)) ? req_id_t'(LSU0) : win_id + 1'b1;
      end else if (bus.lsu_ready) begin
        lsu_valid_d = 1'b0;
      end
      if (pop) req_done_d = id2oh(pop_id);
      if (bus.lsu_done && empty) err_d = 1'b1;
    end
  end

  // Registers; clear is a synchronous flush identical to reset.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      lsu_valid_q <= 1'b0;
      lsu_inst_q  <= '0;
      rr_q        <= '0;
      req_done_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      lsu_valid_q <= lsu_valid_d;
      lsu_inst_q  <= lsu_inst_d;
      rr_q        <= rr_d;
      req_done_q  <= req_done_d;
      err_q       <= err_d;
    end
  end

  dca_lsu_id_fifo #(.DEPTH(TRACK_DEPTH), .BW_CNT(BW_CNT)) u_id_fifo (
    .clk     (clk),
    .rst     (rst),
    .clear   (clear),
    .enable  (enable),
    .push    (grant),
    .push_id (win_id),
    .pop     (pop),
    .pop_id  (pop_id),
    .count   (count)
  );

  assign bus.lsu_valid = lsu_valid_q;
  assign bus.lsu_inst  = lsu_inst_q;
  assign bus.req_done  = req_done_q;
  assign busy          = !empty;
  assign err           = err_q;
endmodule

// File: tb/tb_dca_lsu_issue_arbiter.sv
// Self-checking bench: directed scenarios plus random traffic, all checked
// every cycle against a queue-based behavioural model.
module tb_dca_lsu_issue_arbiter;
  import dca_lsu_issue_arbiter_pkg::*;
  localparam int BW    = 32;
  localparam int DEPTH = 4;

  logic clk, rst, clear, enable, busy, err;
  int   checks = 0, errors = 0;

  dca_lsu_issue_arbiter_if #(.BW_INST(BW)) bus ();

  dca_lsu_issue_arbiter #(.BW_INST(BW), .TRACK_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .clear(clear), .enable(enable),
    .bus(bus), .busy(busy), .err(err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model state.
  int          m_rr;
  logic        m_valid, m_err;
  logic [BW-1:0] m_inst;
  logic [2:0]  m_done;
  int          m_q[$];
  logic [2:0]  last_ready;

  task automatic chk(string tag, logic [BW-1:0] obs, logic [BW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_rr = 0; m_valid = 0; m_err = 0; m_inst = '0; m_done = '0;
    m_q.delete();
  endtask

  // Called at a falling edge with inputs already driven: checks the DUT,
  // advances the model across the next rising edge, returns at next fall.
  task automatic tick();
    logic [2:0] cand, wr, exp_rdy;
    logic g;
    int w, pre;
    #1;
    cand = bus.req_valid;
    wr   = '0;
`ifdef DCA_LSU_ARB_WRITE_PRIORITY_EN
    for (int i = 0; i < 3; i++)
      if (bus.req_valid[i] && bus.req_inst[i*BW +: 4] == DCA_MATRIX_LSU_INST_OPCODE_WRITE) wr[i] = 1'b1;
    if (wr != 0) cand = wr;
`endif
    g = enable && (!m_valid || bus.lsu_ready) && (m_q.size() < DEPTH) && (bus.req_valid != 0);
    w = -1;
    for (int k = 0; k < 3; k++) if (w < 0 && cand[(m_rr + k) % 3]) w = (m_rr + k) % 3;
    exp_rdy = g ? 3'(1 << w) : 3'b000;
    chk("req_ready", 32'(bus.req_ready), 32'(exp_rdy));
    chk("lsu_valid", 32'(bus.lsu_valid), 32'(m_valid));
    chk("lsu_inst",  bus.lsu_inst, m_inst);
    chk("req_done",  32'(bus.req_done), 32'(m_done));
    chk("busy",      32'(busy), 32'(m_q.size() != 0));
    chk("err",       32'(err), 32'(m_err));
    last_ready = bus.req_ready;
    if (rst || clear) model_reset();
    else if (enable) begin
      pre    = m_q.size();
      m_done = '0;
      if (bus.lsu_done) begin
        if (pre == 0) m_err = 1'b1;
        else m_done = 3'(1 << m_q.pop_front());
      end
      if (g) begin
        m_valid = 1'b1;
        m_inst  = bus.req_inst[w*BW +: BW];
        m_q.push_back(w);
        m_rr    = (w + 1) % 3;
      end else if (bus.lsu_ready) m_valid = 1'b0;
    end else m_done = '0;
    @(negedge clk);
  endtask

  task automatic do_clear();
    clear = 1'b1; bus.req_valid = '0; bus.lsu_done = 1'b0; bus.lsu_ready = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  initial begin
    logic [2:0] exp_seq [3];
    exp_seq[0] = 3'b001; exp_seq[1] = 3'b010; exp_seq[2] = 3'b100;
    rst = 1'b1; clear = 1'b0; enable = 1'b1;
    bus.req_valid = '0; bus.req_inst = '0; bus.lsu_ready = 1'b0; bus.lsu_done = 1'b0;
    model_reset();
    @(negedge clk);
    tick();
    rst = 1'b0;

    // Reset then idle.
    tick(); tick();
    chk("idle_lsu_valid", 32'(bus.lsu_valid), 32'd0);
    chk("idle_req_ready", 32'(last_ready), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_err", 32'(err), 32'd0);

    // All three valid, LSU always ready, completion two cycles after issue.
    bus.req_inst = {32'h0000_0301, 32'h0000_0201, 32'h0000_0101};
    bus.req_valid = 3'b111; bus.lsu_ready = 1'b1;
    for (int c = 0; c < 9; c++) begin
      bus.lsu_done = (c >= 2);
      tick();
      chk("rr_order", 32'(last_ready), 32'(exp_seq[c % 3]));
    end
    do_clear();

    // LSU stalled: staged instruction must hold.
    bus.lsu_ready = 1'b0; bus.req_inst = {32'h0, 32'h0000_01A5, 32'h0};
    bus.req_valid = 3'b010;
    tick();
    chk("hold_grant", 32'(last_ready), 32'b010);
    bus.req_valid = 3'b111;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("hold_no_grant", 32'(last_ready), 32'd0);
      chk("hold_inst", bus.lsu_inst, 32'h0000_01A5);
      chk("hold_busy", 32'(busy), 32'd1);
    end
    bus.lsu_ready = 1'b1;
    tick();
    do_clear();

    // Full tracker boundary.
    bus.req_inst = {32'h0, 32'h0, 32'h0000_0010};
    bus.req_valid = 3'b001; bus.lsu_ready = 1'b1;
    for (int c = 0; c < 4; c++) tick();
    tick();
    chk("full_blocks", 32'(last_ready), 32'd0);
    bus.lsu_done = 1'b1;
    tick();
    chk("full_done_same_cycle", 32'(last_ready), 32'd0);
    bus.lsu_done = 1'b0;
    tick();
    chk("full_regrant", 32'(last_ready), 32'b001);
    tick();
    chk("full_again", 32'(last_ready), 32'd0);
    chk("full_busy", 32'(busy), 32'd1);
    do_clear();

    // Completion with empty tracker sets sticky err.
    bus.lsu_done = 1'b1;
    tick();
    bus.lsu_done = 1'b0;
    tick();
    chk("err_set", 32'(err), 32'd1);
    chk("err_no_done", 32'(bus.req_done), 32'd0);
    tick(); tick();
    chk("err_sticky", 32'(err), 32'd1);
    do_clear();
    chk("err_cleared", 32'(err), 32'd0);

`ifdef DCA_LSU_ARB_WRITE_PRIORITY_EN
    // Writer pre-empts round-robin; rr wraps to 0 after granting LSU2.
    bus.req_inst = {32'h0000_0022, 32'h0000_0011, 32'h0000_0011};
    bus.req_valid = 3'b101;
    tick();
    chk("prio_write_first", 32'(last_ready), 32'b100);
    bus.req_valid = 3'b011;
    bus.req_inst = {32'h0000_0011, 32'h0000_0011, 32'h0000_0011};
    tick();
    chk("prio_rr_wrap", 32'(last_ready), 32'b001);
    do_clear();
`endif

    // Random traffic.
    last_ready = '0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 3; i++) begin
        if (last_ready[i] || !bus.req_valid[i]) begin
          bus.req_valid[i] = ($urandom_range(0, 2) != 0);
          bus.req_inst[i*BW +: BW] = $urandom;
        end
      end
      bus.lsu_ready = ($urandom_range(0, 9) < 7);
      bus.lsu_done  = ($urandom_range(0, 9) < 3);
      enable        = ($urandom_range(0, 9) != 0);
      clear         = ($urandom_range(0, 99) == 0);
      tick();
      if (!enable || clear) last_ready = '0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
